// File: rtl/spmv_pkg.sv
// Shared definitions for the SpMV result sink: default geometry, FSM state encoding
// and bit positions inside the sticky error vector.
package spmv_pkg;

    localparam int NUM_ROWS_DEF = 1024;
    localparam int ADDR_W_DEF   = 10;
    localparam int DATA_W_DEF   = 64;
    localparam int OUT_W_DEF    = 32;

    typedef enum logic [1:0] {
        SINK_IDLE    = 2'd0,
        SINK_COLLECT = 2'd1,
        SINK_DRAIN   = 2'd2,
        SINK_DONE    = 2'd3
    } sink_state_e;

    localparam int ERR_RANGE   = 0;
    localparam int ERR_DUP     = 1;
    localparam int ERR_OVERRUN = 2;
    localparam int ERR_W       = 3;

endpackage

// File: rtl/spmv_result_bank.sv
// Simple dual-port result RAM: one write port, one read port with a registered
// 1-cycle read; read data holds while re_i is low. Contents are not reset.
module spmv_result_bank #(
    parameter int DEPTH = 512,
    parameter int AW    = 9,
    parameter int DW    = 64
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/spmv_result_sink.sv
// Captures 2-row result beats into even/odd banks, then drains 2*NUM_ROWS words (lo, hi)
// with a 2-cycle start latency and rd_ready backpressure; `SINK_CHECKSUM_EN adds a drain checksum.
module spmv_result_sink
    import spmv_pkg::*;
#(
    parameter int NUM_ROWS = NUM_ROWS_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int OUT_W    = OUT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] op1,
    input  logic [DATA_W-1:0] op2,
    input  logic [ADDR_W-1:0] addrext,
    input  logic              valid,
    input  logic              zeros,
    input  logic              mul_done,
    output logic [OUT_W-1:0]  rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              rd_last,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   rows_seen,
    output logic              err_range,
    output logic              err_dup,
    output logic              err_overrun,
    output logic [OUT_W-1:0]  checksum
);

    localparam int RW = $clog2(NUM_ROWS);
    localparam logic [ADDR_W:0] ROWS_A   = (ADDR_W+1)'(NUM_ROWS);
    localparam logic [RW:0]     ROWS_F   = (RW+1)'(NUM_ROWS);
    localparam logic [RW:0]     LAST_ROW = (RW+1)'(NUM_ROWS-1);

    sink_state_e state_q, state_d;
    logic [NUM_ROWS-1:0] bitmap_q, bitmap_d;
    logic [ADDR_W:0]     rows_q, rows_d;
    logic [ERR_W-1:0]    err_q, err_d;
    logic [RW:0]         fetch_q, fetch_d;
    logic s1_vld_q, s1_vld_d, s1_half_q, s1_half_d, s1_odd_q, s1_odd_d;
    logic s1_mask_q, s1_mask_d, s1_last_q, s1_last_d;
    logic [OUT_W-1:0]    out_dat_q, out_dat_d;
    logic                out_vld_q, out_vld_d, out_last_q, out_last_d;

    logic arm, beat_in, bad_addr, beat_ok, hs, out_load, s1_done, rd_en;
    logic [RW-1:0]     ev_row, od_row;
    logic [DATA_W-1:0] even_rdata, odd_rdata, row_dat;

    assign arm      = start && (state_q == SINK_IDLE || state_q == SINK_DONE);
    assign beat_in  = valid && (state_q == SINK_COLLECT);
    assign bad_addr = addrext[0] || ({1'b0, addrext} >= ROWS_A);
    assign beat_ok  = beat_in && !bad_addr;
    assign ev_row   = {addrext[RW-1:1], 1'b0};
    assign od_row   = {addrext[RW-1:1], 1'b1};

    assign hs       = out_vld_q && rd_ready;
    assign out_load = (state_q == SINK_DRAIN) && s1_vld_q && (!out_vld_q || rd_ready);
    assign s1_done  = out_load && s1_half_q;
    // Refetch only once the staged row has handed over its high word, so the bank output stays put.
    assign rd_en    = (state_q == SINK_DRAIN) && (fetch_q < ROWS_F) && (!s1_vld_q || s1_done);

    spmv_result_bank #(.DEPTH(NUM_ROWS/2), .AW(RW-1), .DW(DATA_W)) u_bank_even (
        .clk(clk), .we_i(beat_ok), .waddr_i(addrext[RW-1:1]),
        .wdata_i(zeros ? '0 : op1),
        .re_i(rd_en), .raddr_i(fetch_q[RW-1:1]), .rdata_o(even_rdata)
    );

    spmv_result_bank #(.DEPTH(NUM_ROWS/2), .AW(RW-1), .DW(DATA_W)) u_bank_odd (
        .clk(clk), .we_i(beat_ok), .waddr_i(addrext[RW-1:1]),
        .wdata_i(zeros ? '0 : op2),
        .re_i(rd_en), .raddr_i(fetch_q[RW-1:1]), .rdata_o(odd_rdata)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            SINK_IDLE:    if (start) state_d = SINK_COLLECT;
            SINK_COLLECT: if (mul_done) state_d = SINK_DRAIN;
            SINK_DRAIN:   if (hs && out_last_q) state_d = SINK_DONE;
            SINK_DONE:    if (start) state_d = SINK_COLLECT;
            default:      state_d = SINK_IDLE;
        endcase
    end

    always_comb begin
        bitmap_d = bitmap_q;
        rows_d   = rows_q;
        err_d    = err_q;
        if (arm) begin
            bitmap_d = '0;
            rows_d   = '0;
            err_d    = '0;
        end
        if (valid && state_q != SINK_COLLECT) err_d[ERR_OVERRUN] = 1'b1;
        if (beat_in && bad_addr) err_d[ERR_RANGE] = 1'b1;
        if (beat_ok) begin
            if (bitmap_q[ev_row]) err_d[ERR_DUP] = 1'b1;
            else begin
                bitmap_d[ev_row] = 1'b1;
                rows_d = rows_d + (ADDR_W+1)'(1);
            end
            if (bitmap_q[od_row]) err_d[ERR_DUP] = 1'b1;
            else begin
                bitmap_d[od_row] = 1'b1;
                rows_d = rows_d + (ADDR_W+1)'(1);
            end
        end
    end

    always_comb begin
        fetch_d    = fetch_q;
        s1_vld_d   = s1_vld_q;
        s1_half_d  = s1_half_q;
        s1_odd_d   = s1_odd_q;
        s1_mask_d  = s1_mask_q;
        s1_last_d  = s1_last_q;
        out_dat_d  = out_dat_q;
        out_vld_d  = out_vld_q;
        out_last_d = out_last_q;
        row_dat    = s1_mask_q ? (s1_odd_q ? odd_rdata : even_rdata) : '0;

        if (state_q != SINK_DRAIN) begin
            fetch_d  = '0;
            s1_vld_d = 1'b0;
        end
        if (out_load && !s1_half_q) s1_half_d = 1'b1;
        if (s1_done) s1_vld_d = 1'b0;
        if (rd_en) begin
            fetch_d   = fetch_q + (RW+1)'(1);
            s1_vld_d  = 1'b1;
            s1_half_d = 1'b0;
            s1_odd_d  = fetch_q[0];
            s1_mask_d = bitmap_q[fetch_q[RW-1:0]];
            s1_last_d = (fetch_q == LAST_ROW);
        end

        if (hs) begin
            out_vld_d  = 1'b0;
            out_last_d = 1'b0;
        end
        if (out_load) begin
            out_vld_d  = 1'b1;
            out_dat_d  = s1_half_q ? row_dat[DATA_W-1:OUT_W] : row_dat[OUT_W-1:0];
            out_last_d = s1_last_q && s1_half_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= SINK_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bitmap_q   <= '0;
            rows_q     <= '0;
            err_q      <= '0;
            fetch_q    <= '0;
            s1_vld_q   <= 1'b0;
            s1_half_q  <= 1'b0;
            s1_odd_q   <= 1'b0;
            s1_mask_q  <= 1'b0;
            s1_last_q  <= 1'b0;
            out_dat_q  <= '0;
            out_vld_q  <= 1'b0;
            out_last_q <= 1'b0;
        end else begin
            bitmap_q   <= bitmap_d;
            rows_q     <= rows_d;
            err_q      <= err_d;
            fetch_q    <= fetch_d;
            s1_vld_q   <= s1_vld_d;
            s1_half_q  <= s1_half_d;
            s1_odd_q   <= s1_odd_d;
            s1_mask_q  <= s1_mask_d;
            s1_last_q  <= s1_last_d;
            out_dat_q  <= out_dat_d;
            out_vld_q  <= out_vld_d;
            out_last_q <= out_last_d;
        end
    end

`ifdef SINK_CHECKSUM_EN
    logic [OUT_W-1:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (arm)     csum_d = '0;
        else if (hs) csum_d = csum_q + out_dat_q;
    end

    always_ff @(posedge clk) begin
        if (reset) csum_q <= '0;
        else       csum_q <= csum_d;
    end

    assign checksum = csum_q;
`else
    assign checksum = '0;
`endif

    assign rd_data     = out_dat_q;
    assign rd_valid    = out_vld_q;
    assign rd_last     = out_last_q;
    assign busy        = (state_q == SINK_COLLECT) || (state_q == SINK_DRAIN);
    assign done        = (state_q == SINK_DONE);
    assign rows_seen   = rows_q;
    assign err_range   = err_q[ERR_RANGE];
    assign err_dup     = err_q[ERR_DUP];
    assign err_overrun = err_q[ERR_OVERRUN];

endmodule

// File: tb/tb_spmv_result_sink.sv
// Bench for spmv_result_sink (8 rows): row-array reference model, per-cycle drain scoreboard.
module tb_spmv_result_sink;

    localparam int NR = 8;
    localparam int AW = 4;
    localparam int DW = 64;
    localparam int OW = 32;

    logic          clk = 1'b0;
    logic          reset, start, valid, zeros, mul_done, rd_ready;
    logic [DW-1:0] op1, op2;
    logic [AW-1:0] addrext;
    logic [OW-1:0] rd_data, checksum;
    logic          rd_valid, rd_last, busy, done, err_range, err_dup, err_overrun;
    logic [AW:0]   rows_seen;

    always #5 clk = ~clk;

    spmv_result_sink #(.NUM_ROWS(NR), .ADDR_W(AW), .DATA_W(DW), .OUT_W(OW)) dut (
        .clk(clk), .reset(reset), .start(start), .op1(op1), .op2(op2),
        .addrext(addrext), .valid(valid), .zeros(zeros), .mul_done(mul_done),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
        .busy(busy), .done(done), .rows_seen(rows_seen), .err_range(err_range),
        .err_dup(err_dup), .err_overrun(err_overrun), .checksum(checksum)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: what each row holds, which rows were written, sticky flags.
    logic [DW-1:0] m_mem [NR];
    bit            m_wr  [NR];
    int            m_rows;
    bit            m_er, m_ed, m_eo, m_collect;
    logic [OW-1:0] m_csum;
    logic [OW-1:0] exp_q [$];
    logic [OW-1:0] got_w [$];
    int            hs_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic m_clear();
        for (int i = 0; i < NR; i++) m_wr[i] = 1'b0;
        m_rows = 0;
        m_er = 1'b0; m_ed = 1'b0; m_eo = 1'b0;
        m_csum = '0;
    endtask

    task automatic m_beat(input int a, input logic [DW-1:0] d1, input logic [DW-1:0] d2, input bit z);
        if (!m_collect) begin
            m_eo = 1'b1;
            return;
        end
        if ((a % 2) != 0 || a >= NR) begin
            m_er = 1'b1;
            return;
        end
        for (int k = 0; k < 2; k++) begin
            int r;
            r = a + k;
            if (m_wr[r]) m_ed = 1'b1;
            else begin
                m_wr[r] = 1'b1;
                m_rows++;
            end
            m_mem[r] = z ? '0 : ((k == 0) ? d1 : d2);
        end
    endtask

    task automatic m_build_drain();
        logic [DW-1:0] w;
        exp_q.delete();
        got_w.delete();
        hs_cnt = 0;
        for (int r = 0; r < NR; r++) begin
            w = m_wr[r] ? m_mem[r] : '0;
            exp_q.push_back(w[OW-1:0]);
            exp_q.push_back(w[DW-1:OW]);
        end
    endtask

    // Drivers: each begins and ends 1 time unit after a rising edge.
    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        m_clear();
        m_collect = 1'b0;
        exp_q.delete();
        #1 reset = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        m_clear();
        m_collect = 1'b1;
        #1 start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic beat(input int a, input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                        input bit z, input bit with_done);
        valid = 1'b1; addrext = a[AW-1:0]; op1 = d1; op2 = d2; zeros = z; mul_done = with_done;
        @(posedge clk);
        m_beat(a, d1, d2, z);
        if (with_done) begin
            m_collect = 1'b0;
            m_build_drain();
        end
        #1 valid = 1'b0; zeros = 1'b0; mul_done = 1'b0;
    endtask

    task automatic finish_collect();
        mul_done = 1'b1;
        @(posedge clk);
        m_collect = 1'b0;
        m_build_drain();
        #1 mul_done = 1'b0;
    endtask

    // mode 0: ready held high; 1: ready toggles each cycle; 2: random ready.
    task automatic drain(input int mode, output int cycles);
        int n;
        logic [OW-1:0] req_cs;
        n = 0;
        rd_ready = (mode != 1);
        while (!done && n < 400) begin
            @(posedge clk);
            #1;
            n++;
            if (mode == 1) rd_ready = ~rd_ready;
            else if (mode == 2) rd_ready = 1'($urandom_range(0, 1));
        end
        cycles = n;
        rd_ready = 1'b1;
        check("drain_done", done, 1'b1);
        check("drain_busy", busy, 1'b0);
        check("drain_words", got_w.size(), 16);
        check("drain_left", exp_q.size(), 0);
`ifdef SINK_CHECKSUM_EN
        req_cs = m_csum;
`else
        req_cs = '0;
`endif
        check("checksum", checksum, req_cs);
    endtask

    // Per-cycle scoreboard on the falling edge.
    logic [OW-1:0] prev_dat, cmp_w;
    bit            prev_stall = 1'b0;
    bit            prev_last;

    always @(negedge clk) begin
        if (!reset) begin
            if (prev_stall) begin
                check("stall_valid", rd_valid, 1'b1);
                check("stall_data", rd_data, prev_dat);
                check("stall_last", rd_last, prev_last);
            end
            if (rd_valid && rd_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_word actual=%h required=none", rd_data);
                end else begin
                    cmp_w = exp_q.pop_front();
                    check("word", rd_data, cmp_w);
                    check("last", rd_last, exp_q.size() == 0);
                    got_w.push_back(rd_data);
                    m_csum = m_csum + cmp_w;
                    hs_cnt++;
                end
            end
            check("rows_seen", rows_seen, m_rows);
            check("err_range", err_range, m_er);
            check("err_dup", err_dup, m_ed);
            check("err_overrun", err_overrun, m_eo);
        end
        prev_stall = !reset && rd_valid && !rd_ready;
        prev_dat   = rd_data;
        prev_last  = rd_last;
    end

    initial begin
        int cyc, nb, n;
        reset = 1'b1; start = 1'b0; valid = 1'b0; zeros = 1'b0; mul_done = 1'b0;
        rd_ready = 1'b0; addrext = '0; op1 = '0; op2 = '0;
        m_collect = 1'b0; hs_cnt = 0; m_clear();

        do_reset();
        check("rst_rd_valid", rd_valid, 1'b0);
        check("rst_rd_last", rd_last, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_rows", rows_seen, 0);
        check("rst_errs", {err_range, err_dup, err_overrun}, 3'b000);
        check("rst_checksum", checksum, 0);

        // Basic full drain at full throughput.
        do_start();
        check("start_busy", busy, 1'b1);
        beat(0, {32'hA1, 32'hA0}, {32'hA3, 32'hA2}, 1'b0, 1'b0);
        beat(2, {32'hB1, 32'hB0}, {32'hB3, 32'hB2}, 1'b0, 1'b0);
        beat(4, {32'hC1, 32'hC0}, {32'hC3, 32'hC2}, 1'b0, 1'b0);
        beat(6, {32'hD1, 32'hD0}, {32'hD3, 32'hD2}, 1'b0, 1'b0);
        rd_ready = 1'b1;
        finish_collect();
        drain(0, cyc);
        check("basic_cycles", cyc, 18);
        check("basic_w0", got_w[0], 32'hA0);
        check("basic_w3", got_w[3], 32'hA3);
        check("basic_w15", got_w[15], 32'hD3);
        check("basic_rows", rows_seen, 8);
        check("basic_errs", {err_range, err_dup, err_overrun}, 3'b000);

        // Sparse rows and a zeros beat.
        do_start();
        beat(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'hEEEE_EEEE_EEEE_EEEE, 1'b1, 1'b0);
        beat(6, 64'h1234_5678_9ABC_DEF0, 64'hCAFE_F00D_0BAD_BEEF, 1'b0, 1'b0);
        finish_collect();
        drain(2, cyc);
        check("sparse_rows", rows_seen, 4);
        check("sparse_w4", got_w[4], 32'h0);
        check("sparse_w12", got_w[12], 32'h9ABC_DEF0);
        check("sparse_w15", got_w[15], 32'hCAFE_F00D);

        // Protocol errors.
        do_start();
        beat(3, 64'h33, 64'h34, 1'b0, 1'b0);
        check("odd_addr_range", err_range, 1'b1);
        beat(10, 64'h55, 64'h56, 1'b0, 1'b0);
        beat(0, 64'h1111, 64'h2222, 1'b0, 1'b0);
        check("dup_clear", err_dup, 1'b0);
        beat(0, 64'h7777_0000_8888, 64'h9999, 1'b0, 1'b0);
        check("dup_set", err_dup, 1'b1);
        finish_collect();
        drain(0, cyc);
        check("dup_last_wins", got_w[0], 32'h0000_8888);
        check("dup_rows", rows_seen, 2);
        beat(2, 64'h1, 64'h2, 1'b0, 1'b0);
        check("overrun_set", err_overrun, 1'b1);
        check("overrun_done", done, 1'b1);

        // Backpressure toggling every cycle.
        do_start();
        for (int i = 0; i < NR; i += 2)
            beat(i, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0);
        finish_collect();
        drain(1, cyc);

        // Beat in the same cycle as mul_done.
        do_start();
        beat(0, 64'h10, 64'h20, 1'b0, 1'b0);
        beat(6, 64'h6060_0000_6161_0000, 64'h5151_0000_5150_0000, 1'b0, 1'b1);
        drain(0, cyc);
        check("simul_w14", got_w[14], 32'h5150_0000);
        check("simul_rows", rows_seen, 4);

        // Reset in the middle of a drain, then a clean restart.
        do_start();
        for (int i = 0; i < NR; i += 2)
            beat(i, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0);
        rd_ready = 1'b1;
        finish_collect();
        n = 0;
        while (hs_cnt < 5 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("mid_reached", hs_cnt >= 5, 1'b1);
        do_reset();
        check("mid_rd_valid", rd_valid, 1'b0);
        check("mid_busy", busy, 1'b0);
        check("mid_done", done, 1'b0);
        do_start();
        for (int i = 0; i < NR; i += 2)
            beat(i, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0);
        finish_collect();
        drain(0, cyc);
        check("restart_cycles", cyc, 18);

        // Checksum pattern: every word equals 1.
        do_start();
        for (int i = 0; i < NR; i += 2)
            beat(i, 64'h1_0000_0001, 64'h1_0000_0001, 1'b0, 1'b0);
        finish_collect();
        drain(2, cyc);
`ifdef SINK_CHECKSUM_EN
        check("csum_literal", checksum, 32'h10);
`else
        check("csum_tied", checksum, 32'h0);
`endif

        // Randomized rounds.
        for (int t = 0; t < 8; t++) begin
            do_start();
            nb = $urandom_range(0, 10);
            for (int b = 0; b < nb; b++) begin
                idle($urandom_range(0, 2));
                beat($urandom_range(0, NR + 3), {$urandom, $urandom}, {$urandom, $urandom},
                     ($urandom_range(0, 3) == 0), (b == nb - 1) && ($urandom_range(0, 1) == 1));
            end
            if (busy && exp_q.size() == 0) finish_collect();
            else if (!busy || got_w.size() != 0 || exp_q.size() != 16) finish_collect();
            drain(2, cyc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
